// File: rtl/bcd_converter.sv
// Sequential binary-to-BCD converter (shift-and-add-3). One conversion per accepted
// start; bcd/ovf hold their value until the next completion or a clear.
`timescale 1ns/1ps
module bcd_converter #(
   parameter int WIDTH  = 32,
   parameter int DIGITS = 8
) (
   input  logic                clk,
   input  logic                clr,
   input  logic                start,
   input  logic [WIDTH-1:0]    bin,
   output logic                busy,
   output logic                done,
   output logic                ovf,
   output logic [4*DIGITS-1:0] bcd,
   output logic [1:0]          state_o
);

   // Handshake: start is taken on a rising edge only while busy=0; bin is captured on
   // that same edge. busy stays high until done pulses for one cycle with bcd/ovf updated.
   localparam int NI  = (WIDTH*301)/1000 + 1;
   localparam int SRW = 4*NI + WIDTH;
   localparam int CW  = $clog2(WIDTH+1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_DONE  = 2'd2
   } state_t;

   state_t              state_q, state_d;
   logic [SRW-1:0]      sr_q, sr_d;
   logic [CW-1:0]       cnt_q, cnt_d;
   logic [4*DIGITS-1:0] bcd_q, bcd_d;
   logic                ovf_q, ovf_d;
   logic                done_q, done_d;

   logic [SRW-1:0]      sr_adj;
   logic [SRW-1:0]      sr_shl;
   logic                hi_nz;
   logic                nib_ok;

   // BCD digits live above the binary field; each step corrects them, then shifts.
   always_comb begin
      sr_adj = sr_q;
      for (int i = 0; i < NI; i++) begin
         if (sr_adj[WIDTH+4*i +: 4] > 4'd4)
            sr_adj[WIDTH+4*i +: 4] = sr_adj[WIDTH+4*i +: 4] + 4'd3;
      end
      sr_shl = sr_adj << 1;

      nib_ok = 1'b1;
      for (int i = 0; i < NI; i++) begin
         if (sr_shl[WIDTH+4*i +: 4] > 4'd9)
            nib_ok = 1'b0;
      end

      hi_nz = 1'b0;
      for (int i = DIGITS; i < NI; i++) begin
         hi_nz = hi_nz | (sr_q[WIDTH+4*i +: 4] != 4'd0);
      end
   end

   always_comb begin
      state_d = state_q;
      sr_d    = sr_q;
      cnt_d   = cnt_q;
      bcd_d   = bcd_q;
      ovf_d   = ovf_q;
      done_d  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               sr_d    = {{(4*NI){1'b0}}, bin};
               cnt_d   = CW'(WIDTH);
               state_d = ST_SHIFT;
            end
         end
         ST_SHIFT: begin
            sr_d  = sr_shl;
            cnt_d = cnt_q - CW'(1);
            if (cnt_q == CW'(1))
               state_d = ST_DONE;
         end
         ST_DONE: begin
            // Digits beyond the displayable range saturate the output to all nines.
            if (hi_nz) begin
               bcd_d = {DIGITS{4'h9}};
               ovf_d = 1'b1;
            end else begin
               bcd_d = sr_q[WIDTH +: 4*DIGITS];
               ovf_d = 1'b0;
            end
            done_d  = 1'b1;
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (clr) begin
         state_q <= ST_IDLE;
         sr_q    <= '0;
         cnt_q   <= '0;
         bcd_q   <= '0;
         ovf_q   <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         sr_q    <= sr_d;
         cnt_q   <= cnt_d;
         bcd_q   <= bcd_d;
         ovf_q   <= ovf_d;
         done_q  <= done_d;
      end
   end

   always_ff @(posedge clk) begin
      if (!clr && state_q == ST_SHIFT)
         assert (nib_ok);
   end

   assign busy    = (state_q != ST_IDLE);
   assign done    = done_q;
   assign ovf     = ovf_q;
   assign bcd     = bcd_q;
   assign state_o = state_q;

endmodule

// File: tb/tb_bcd_converter.sv
// Directed bench for bcd_converter: expected {ovf,bcd} values are queued at issue time
// and a negedge monitor pops and compares them whenever done pulses.
`timescale 1ns/1ps
module tb_bcd_converter;

   localparam int W = 33;

   logic        clk = 1'b0;
   logic        clr;
   logic        start;
   logic [31:0] bin;
   logic        busy;
   logic        done;
   logic        ovf;
   logic [31:0] bcd;
   logic [1:0]  state_o;

   int          n_checks = 0;
   int          n_pass   = 0;
   logic [W-1:0] exp_q[$];
   logic [W-1:0] mon_e;
   bit          mon_en = 1'b0;

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;

   bcd_converter #(.WIDTH(32), .DIGITS(8)) dut (
      .clk     (clk),
      .clr     (clr),
      .start   (start),
      .bin     (bin),
      .busy    (busy),
      .done    (done),
      .ovf     (ovf),
      .bcd     (bcd),
      .state_o (state_o)
   );

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout want completion");
      $fatal(1, "watchdog");
   end

   // ---------------- helpers ----------------
   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h want %0h", name, act, exp);
   endtask

   function automatic logic [W-1:0] model(input logic [31:0] v);
      logic [31:0] r;
      logic [31:0] x;
      if (v > 32'd99999999) return {1'b1, 32'h99999999};
      r = '0;
      x = v;
      for (int i = 0; i < 8; i++) begin
         r[4*i +: 4] = 4'(x % 10);
         x = x / 10;
      end
      return {1'b0, r};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // ---------------- driver tasks ----------------
   task automatic issue(input logic [31:0] v, input logic [W-1:0] e);
      exp_q.push_back(e);
      start = 1'b1;
      bin   = v;
      tick();
      start = 1'b0;
      bin   = 32'hdead_beef;
      check("busy_after_start", 64'(busy), 64'd1);
   endtask

   // Follows a conversion already in flight: busy length, bcd stability, done width.
   task automatic wait_done(input string name, input logic [31:0] prev);
      int cnt;
      bit unstable;
      cnt = 0;
      unstable = 1'b0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (!busy) break;
         cnt++;
         if (bcd !== prev || done !== 1'b0) unstable = 1'b1;
      end
      check({name, "_busy_cycles"}, 64'(cnt), 64'd33);
      check({name, "_stable"}, 64'(unstable), 64'd0);
      check({name, "_done_hi"}, 64'(done), 64'd1);
      @(negedge clk);
      check({name, "_done_lo"}, 64'(done), 64'd0);
      tick();
   endtask

   // ---------------- scoreboard monitor ----------------
   always @(negedge clk) begin
      if (mon_en && done === 1'b1) begin
         if (exp_q.size() == 0) begin
            n_checks++;
            $display("FAIL unexpected_done: got bcd=%h ovf=%b want no done", bcd, ovf);
         end else begin
            mon_e = exp_q.pop_front();
            check("sb_bcd", 64'(bcd), 64'(mon_e[31:0]));
            check("sb_ovf", 64'(ovf), 64'(mon_e[32]));
         end
      end
   end

   // ---------------- stimulus ----------------
   logic [31:0]  vin  [6];
   logic [W-1:0] vexp [6];
   logic [31:0]  prev;
   logic [31:0]  rv;
   int           pulses;

   initial begin
      vin[0] = 32'd99999999;  vexp[0] = {1'b0, 32'h99999999};
      vin[1] = 32'd100000000; vexp[1] = {1'b1, 32'h99999999};
      vin[2] = 32'hFFFFFFFF;  vexp[2] = {1'b1, 32'h99999999};
      vin[3] = 32'd9;         vexp[3] = {1'b0, 32'h00000009};
      vin[4] = 32'd10;        vexp[4] = {1'b0, 32'h00000010};
      vin[5] = 32'd305419896; vexp[5] = {1'b1, 32'h99999999};

      clr = 1'b1; start = 1'b0; bin = '0;
      repeat (2) @(posedge clk);
      #1;
      clr = 1'b0;
      @(negedge clk);
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_done", 64'(done), 64'd0);
      check("rst_ovf", 64'(ovf), 64'd0);
      check("rst_bcd", 64'(bcd), 64'd0);
      check("rst_state", 64'(state_o), 64'd0);
      tick();
      mon_en = 1'b1;

      // zero and a full-width eight-digit value
      issue(32'd0, {1'b0, 32'h00000000});
      wait_done("zero", 32'h0);
      issue(32'd12345678, {1'b0, 32'h12345678});
      wait_done("t2", 32'h0);
      prev = 32'h12345678;

      // boundary table: largest displayable, first overflow, all ones, small values
      for (int i = 0; i < 6; i++) begin
         issue(vin[i], vexp[i]);
         wait_done("tbl", prev);
         prev = vexp[i][31:0];
      end

      // start while busy is ignored; start held into the done cycle is accepted
      exp_q.push_back({1'b0, 32'h00000042});
      exp_q.push_back({1'b0, 32'h00000007});
      start = 1'b1; bin = 32'd42;
      tick();
      start = 1'b0;
      repeat (9) tick();
      check("t4_busy_mid", 64'(busy), 64'd1);
      start = 1'b1; bin = 32'd7;
      pulses = 0;
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         if (done === 1'b1) begin pulses = 1; break; end
      end
      check("t4_first_done", 64'(pulses), 64'd1);
      check("t4_first_bcd", 64'(bcd), 64'h42);
      tick();
      start = 1'b0;
      check("t4_reaccept_busy", 64'(busy), 64'd1);
      wait_done("t4b", 32'h42);
      prev = 32'h7;

      // a few random in-range values against the decimal model
      for (int i = 0; i < 12; i++) begin
         rv = $urandom_range(0, 99999999);
         issue(rv, model(rv));
         wait_done("rnd", prev);
         prev = model(rv);
      end

      // clear aborts a conversion in flight and wipes the held result
      issue(32'hFFFFFFFF, {1'b1, 32'h99999999});
      wait_done("pre_abort", prev);
      check("pre_abort_ovf", 64'(ovf), 64'd1);
      start = 1'b1; bin = 32'd555;
      tick();
      start = 1'b0;
      repeat (14) tick();
      clr = 1'b1;
      tick();
      clr = 1'b0;
      check("abort_busy", 64'(busy), 64'd0);
      check("abort_done", 64'(done), 64'd0);
      check("abort_bcd", 64'(bcd), 64'd0);
      check("abort_ovf", 64'(ovf), 64'd0);
      check("abort_state", 64'(state_o), 64'd0);
      pulses = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (done === 1'b1) pulses++;
      end
      check("abort_no_done", 64'(pulses), 64'd0);
      check("sb_drained", 64'(exp_q.size()), 64'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
